pq_arbiter: RTL and testbench

Shares a single `register_array` max-priority queue between `NUM_REQ` independent requesters. Each requester posts an enqueue, dequeue or replace operation. A round-robin arbiter picks one per slot and drives the queue's `i_wrt`/`i_read`/`i_data` strobes. Before issue it screens each op against the queue's full/empty flags, and it returns the removed root value, or an error, to the winning requester. It sits between client logic and the queue instance and is the only block that drives the queue's write/read strobes.

---
 rtl/pq_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_pq_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pq_arbiter.sv
// Round-robin front end that lets NUM_REQ clients share one max-priority queue; grant+strobe one cycle after request, response one cycle later.
// Backpressure: a requester holds i_req/i_op/i_data until its o_gnt pulse; the arbiter serves one op per 3+OP_GAP cycles.
module pq_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int OP_GAP     = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [2*NUM_REQ-1:0]          i_op,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] i_data,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_rsp_err,
  output logic                          o_busy,
  output logic                          o_q_wrt,
  output logic                          o_q_read,
  output logic [DATA_WIDTH-1:0]         o_q_data,
  input  logic                          i_q_full,
  input  logic                          i_q_empty,
  input  logic [DATA_WIDTH-1:0]         i_q_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] OP_ENQ = 2'b00;
  localparam logic [1:0] OP_DEQ = 2'b01;
  localparam logic [1:0] OP_REP = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, WAIT} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]        win_q, win_d;
  logic [1:0]              op_q, op_d;
  logic                    err_q, err_d;
  logic [3:0]              gap_q, gap_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    busy_q, busy_d;
  logic                    q_wrt_q, q_wrt_d;
  logic                    q_read_q, q_read_d;
  logic [DATA_WIDTH-1:0]   q_data_q, q_data_d;

  logic                    found_hi, found_lo;
  logic [IDX_W-1:0]        pick_hi, pick_lo, pick;
  logic [1:0]              pick_op_hi, pick_op_lo, pick_op;
  logic [DATA_WIDTH-1:0]   pick_dat_hi, pick_dat_lo, pick_dat;
  logic                    pick_legal;

  // Two-pass search: indices above rr_ptr first, then wrap to the low side; lowest index in each pass wins.
  always_comb begin
    found_hi    = 1'b0;
    found_lo    = 1'b0;
    pick_hi     = '0;
    pick_lo     = '0;
    pick_op_hi  = '0;
    pick_op_lo  = '0;
    pick_dat_hi = '0;
    pick_dat_lo = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        if (k > int'(rr_ptr_q)) begin
          found_hi    = 1'b1;
          pick_hi     = IDX_W'(k);
          pick_op_hi  = i_op[2*k +: 2];
          pick_dat_hi = i_data[DATA_WIDTH*k +: DATA_WIDTH];
        end else begin
          found_lo    = 1'b1;
          pick_lo     = IDX_W'(k);
          pick_op_lo  = i_op[2*k +: 2];
          pick_dat_lo = i_data[DATA_WIDTH*k +: DATA_WIDTH];
        end
      end
    end
    pick     = found_hi ? pick_hi     : pick_lo;
    pick_op  = found_hi ? pick_op_hi  : pick_op_lo;
    pick_dat = found_hi ? pick_dat_hi : pick_dat_lo;

    case (pick_op)
      OP_ENQ:         pick_legal = !i_q_full;
      OP_DEQ, OP_REP: pick_legal = !i_q_empty;
      default:        pick_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    op_d        = op_q;
    err_d       = err_q;
    gap_d       = gap_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;
    q_wrt_d     = 1'b0;
    q_read_d    = 1'b0;
    q_data_d    = '0;

    case (state_q)
      IDLE: begin
        if (|i_req) begin
          win_d    = pick;
          op_d     = pick_op;
          err_d    = !pick_legal;
          gnt_d    = NUM_REQ'(1) << pick;
          q_wrt_d  = pick_legal && (pick_op == OP_ENQ || pick_op == OP_REP);
          q_read_d = pick_legal && (pick_op == OP_DEQ || pick_op == OP_REP);
          q_data_d = pick_legal ? pick_dat : '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // The queue still shows the pre-op root this cycle, so it is the value being removed.
        rr_ptr_d    = win_q;
        rsp_valid_d = NUM_REQ'(1) << win_q;
        rsp_err_d   = err_q;
        rsp_data_d  = (!err_q && op_q != OP_ENQ) ? i_q_data : '0;
        state_d     = RESP;
      end
      RESP: begin
        if (OP_GAP > 0) begin
          gap_d   = 4'(OP_GAP - 1);
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
      win_q       <= '0;
      op_q        <= '0;
      err_q       <= 1'b0;
      gap_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      q_wrt_q     <= 1'b0;
      q_read_q    <= 1'b0;
      q_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      op_q        <= op_d;
      err_q       <= err_d;
      gap_q       <= gap_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      q_wrt_q     <= q_wrt_d;
      q_read_q    <= q_read_d;
      q_data_q    <= q_data_d;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_busy      = busy_q;
  assign o_q_wrt     = q_wrt_q;
  assign o_q_read    = q_read_q;
  assign o_q_data    = q_data_q;

endmodule

// File: tb/tb_pq_arbiter.sv
// Directed bench for pq_arbiter with a behavioural 8-entry max-priority queue attached to the strobe side.
module tb_pq_arbiter;
  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int GAP = 1;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [N-1:0]    i_req = '0;
  logic [2*N-1:0]  i_op = '0;
  logic [DW*N-1:0] i_data = '0;
  logic [N-1:0]    o_gnt, o_rsp_valid;
  logic [DW-1:0]   o_rsp_data, o_q_data;
  logic            o_rsp_err, o_busy, o_q_wrt, o_q_read;
  logic            q_full = 1'b0;
  logic            q_empty = 1'b1;
  logic [DW-1:0]   q_root = '0;
  logic            mdl_clr = 1'b0;
  logic [DW-1:0]   qm[$];
  int              n_cmp = 0;
  int              n_fail = 0;

  pq_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .OP_GAP(GAP)) dut (
    .CLK(CLK), .RST(RST), .i_req(i_req), .i_op(i_op), .i_data(i_data),
    .o_gnt(o_gnt), .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_busy(o_busy), .o_q_wrt(o_q_wrt), .o_q_read(o_q_read), .o_q_data(o_q_data),
    .i_q_full(q_full), .i_q_empty(q_empty), .i_q_data(q_root)
  );

  always #5 CLK = ~CLK;

  // Queue model kept sorted in descending order; entry 0 is the root.
  always @(posedge CLK) begin
    int pos;
    if (mdl_clr) begin
      qm.delete();
    end else begin
      if (o_q_read && qm.size() > 0) void'(qm.pop_front());
      if (o_q_wrt && qm.size() < 8) begin
        pos = qm.size();
        for (int i = qm.size() - 1; i >= 0; i--) if (qm[i] < o_q_data) pos = i;
        qm.insert(pos, o_q_data);
      end
    end
    q_full  <= (qm.size() == 8);
    q_empty <= (qm.size() == 0);
    q_root  <= (qm.size() > 0) ? qm[0] : '0;
  end

  task automatic reset_all();
    @(negedge CLK);
    RST = 1'b1; mdl_clr = 1'b1; i_req = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0; mdl_clr = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 20 && o_busy !== 1'b0; c++) @(negedge CLK);
  endtask

  // Posts one op and records what the DUT did in the grant cycle and the response cycle.
  task automatic run_op(input int k, input logic [1:0] op, input logic [DW-1:0] d,
                        output logic [N-1:0] g, output logic w, output logic r, output logic [DW-1:0] qd,
                        output logic [N-1:0] rv, output logic [DW-1:0] rd, output logic re,
                        output int gl, output int rl, output logic w2, output logic r2, output logic [N-1:0] g2);
    g = '0; w = 1'bx; r = 1'bx; qd = 'x; rv = '0; rd = 'x; re = 1'bx;
    gl = -1; rl = -1; w2 = 1'bx; r2 = 1'bx; g2 = 'x;
    wait_idle();
    i_req[k] = 1'b1; i_op[2*k +: 2] = op; i_data[DW*k +: DW] = d;
    for (int c = 1; c <= 30 && rl < 0; c++) begin
      @(negedge CLK);
      if (o_gnt !== '0 && gl < 0) begin
        g = o_gnt; w = o_q_wrt; r = o_q_read; qd = o_q_data; gl = c; i_req[k] = 1'b0;
      end
      if (o_rsp_valid !== '0) begin
        rv = o_rsp_valid; rd = o_rsp_data; re = o_rsp_err; rl = c;
        w2 = o_q_wrt; r2 = o_q_read; g2 = o_gnt;
      end
    end
    i_req[k] = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; mdl_clr = 1'b1; i_req = '1; i_op = '0;
    i_data = {16'd4, 16'd3, 16'd2, 16'd1};
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      n_cmp++; if (o_gnt !== '0 || o_rsp_valid !== '0) begin n_fail++; $display("FAIL reset_gnt_rsp[%0d]: got gnt=%b rsp=%b, expected 0000/0000", c, o_gnt, o_rsp_valid); end
      n_cmp++; if (o_q_wrt !== 1'b0 || o_q_read !== 1'b0 || o_q_data !== '0) begin n_fail++; $display("FAIL reset_strobes[%0d]: got wrt=%b read=%b data=%0d, expected 0/0/0", c, o_q_wrt, o_q_read, o_q_data); end
      n_cmp++; if (o_busy !== 1'b0 || o_rsp_err !== 1'b0 || o_rsp_data !== '0) begin n_fail++; $display("FAIL reset_misc[%0d]: got busy=%b err=%b data=%0d, expected 0/0/0", c, o_busy, o_rsp_err, o_rsp_data); end
    end
    RST = 1'b0; mdl_clr = 1'b0;
    @(negedge CLK);
    n_cmp++; if (o_gnt !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt: got %b, expected 0001", o_gnt); end
    n_cmp++; if (o_q_wrt !== 1'b1 || o_q_data !== 16'd1) begin n_fail++; $display("FAIL reset_first_enq: got wrt=%b data=%0d, expected 1/1", o_q_wrt, o_q_data); end
    i_req = '0;
    @(negedge CLK);
    n_cmp++; if (o_rsp_valid !== 4'b0001 || o_rsp_err !== 1'b0 || o_rsp_data !== '0) begin n_fail++; $display("FAIL reset_first_rsp: got v=%b err=%b data=%0d, expected 0001/0/0", o_rsp_valid, o_rsp_err, o_rsp_data); end
  endtask

  task automatic test_round_robin();
    int gidx[5];
    int gcyc[5];
    int ng, nr, errs;
    ng = 0; nr = 0; errs = 0;
    for (int i = 0; i < 5; i++) begin gidx[i] = -1; gcyc[i] = -100; end
    reset_all();
    for (int k = 0; k < N; k++) begin i_op[2*k +: 2] = 2'b00; i_data[DW*k +: DW] = DW'(10 * (k + 1)); end
    i_req = '1;
    for (int c = 1; c <= 60 && nr < 5; c++) begin
      @(negedge CLK);
      if (o_gnt !== '0 && ng < 5) begin
        for (int k = 0; k < N; k++) if (o_gnt[k]) gidx[ng] = k;
        gcyc[ng] = c; ng++;
        if (ng == 5) i_req = '0;
      end
      if (o_rsp_valid !== '0) begin
        if (o_rsp_err !== 1'b0) errs++;
        nr++;
      end
    end
    i_req = '0;
    n_cmp++; if (ng != 5 || nr != 5) begin n_fail++; $display("FAIL rr_counts: got grants=%0d rsps=%0d, expected 5/5", ng, nr); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (gidx[i] != i % N) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d, expected %0d", i, gidx[i], i % N); end
    end
    for (int i = 1; i < 5; i++) begin
      n_cmp++; if (gcyc[i] - gcyc[i-1] != 3 + GAP) begin n_fail++; $display("FAIL rr_spacing[%0d]: got %0d, expected %0d", i, gcyc[i] - gcyc[i-1], 3 + GAP); end
    end
    n_cmp++; if (errs != 0) begin n_fail++; $display("FAIL rr_err: got %0d errored responses, expected 0", errs); end
    n_cmp++; if (qm.size() != 5 || qm[0] !== 16'd40) begin n_fail++; $display("FAIL rr_root: got size=%0d root=%0d, expected 5/40", qm.size(), qm[0]); end
  endtask

  task automatic test_full_reject();
    logic [N-1:0] g, rv, g2; logic w, r, re, w2, r2; logic [DW-1:0] qd, rd; int gl, rl;
    reset_all();
    for (int i = 0; i < 8; i++) run_op(0, 2'b00, DW'(100 + i), g, w, r, qd, rv, rd, re, gl, rl, w2, r2, g2);
    n_cmp++; if (q_full !== 1'b1) begin n_fail++; $display("FAIL full_setup: got full=%b, expected 1", q_full); end
    run_op(2, 2'b00, 16'd500, g, w, r, qd, rv, rd, re, gl, rl, w2, r2, g2);
    n_cmp++; if (g !== 4'b0100 || w !== 1'b0 || r !== 1'b0) begin n_fail++; $display("FAIL full_strobe: got gnt=%b wrt=%b read=%b, expected 0100/0/0", g, w, r); end
    n_cmp++; if (rv !== 4'b0100 || re !== 1'b1 || rd !== '0) begin n_fail++; $display("FAIL full_rsp: got v=%b err=%b data=%0d, expected 0100/1/0", rv, re, rd); end
    n_cmp++; if (qm.size() != 8 || qm[0] !== 16'd107 || qm[7] !== 16'd100) begin n_fail++; $display("FAIL full_contents: got size=%0d root=%0d last=%0d, expected 8/107/100", qm.size(), qm[0], qm[7]); end
  endtask

  task automatic test_dequeue_order();
    logic [N-1:0] g, rv, g2; logic w, r, re, w2, r2; logic [DW-1:0] qd, rd; int gl, rl;
    logic [DW-1:0] exp_d[3];
    exp_d[0] = 16'd900; exp_d[1] = 16'd33; exp_d[2] = 16'd7;
    reset_all();
    run_op(1, 2'b00, 16'd7,   g, w, r, qd, rv, rd, re, gl, rl, w2, r2, g2);
    run_op(1, 2'b00, 16'd900, g, w, r, qd, rv, rd, re, gl, rl, w2, r2, g2);
    run_op(1, 2'b00, 16'd33,  g, w, r, qd, rv, rd, re, gl, rl, w2, r2, g2);
    for (int i = 0; i < 3; i++) begin
      run_op(1, 2'b01, 16'd0, g, w, r, qd, rv, rd, re, gl, rl, w2, r2, g2);
      n_cmp++; if (rv !== 4'b0010 || re !== 1'b0 || rd !== exp_d[i]) begin n_fail++; $display("FAIL deq_data[%0d]: got v=%b err=%b data=%0d, expected 0010/0/%0d", i, rv, re, rd, exp_d[i]); end
      n_cmp++; if (w !== 1'b0 || r !== 1'b1) begin n_fail++; $display("FAIL deq_strobe[%0d]: got wrt=%b read=%b, expected 0/1", i, w, r); end
      n_cmp++; if (gl != 1 || rl != 2) begin n_fail++; $display("FAIL deq_latency[%0d]: got gnt@%0d rsp@%0d, expected 1/2", i, gl, rl); end
    end
    run_op(1, 2'b01, 16'd0, g, w, r, qd, rv, rd, re, gl, rl, w2, r2, g2);
    n_cmp++; if (rv !== 4'b0010 || re !== 1'b1 || rd !== '0 || r !== 1'b0) begin n_fail++; $display("FAIL deq_empty: got v=%b err=%b data=%0d read=%b, expected 0010/1/0/0", rv, re, rd, r); end
    n_cmp++; if (q_empty !== 1'b1) begin n_fail++; $display("FAIL deq_empty_flag: got %b, expected 1", q_empty); end
  endtask

  task automatic test_replace();
    logic [N-1:0] g, rv, g2; logic w, r, re, w2, r2; logic [DW-1:0] qd, rd; int gl, rl;
    reset_all();
    run_op(3, 2'b00, 16'd50, g, w, r, qd, rv, rd, re, gl, rl, w2, r2, g2);
    run_op(3, 2'b00, 16'd20, g, w, r, qd, rv, rd, re, gl, rl, w2, r2, g2);
    run_op(3, 2'b10, 16'd5,  g, w, r, qd, rv, rd, re, gl, rl, w2, r2, g2);
    n_cmp++; if (g !== 4'b1000 || w !== 1'b1 || r !== 1'b1 || qd !== 16'd5) begin n_fail++; $display("FAIL rep_strobe: got gnt=%b wrt=%b read=%b data=%0d, expected 1000/1/1/5", g, w, r, qd); end
    n_cmp++; if (w2 !== 1'b0 || r2 !== 1'b0 || g2 !== '0) begin n_fail++; $display("FAIL rep_width: got wrt=%b read=%b gnt=%b in rsp cycle, expected 0/0/0000", w2, r2, g2); end
    n_cmp++; if (rv !== 4'b1000 || re !== 1'b0 || rd !== 16'd50) begin n_fail++; $display("FAIL rep_rsp: got v=%b err=%b data=%0d, expected 1000/0/50", rv, re, rd); end
    n_cmp++; if (qm.size() != 2 || qm[0] !== 16'd20) begin n_fail++; $display("FAIL rep_root: got size=%0d root=%0d, expected 2/20", qm.size(), qm[0]); end
  endtask

  task automatic test_reset_midop_reserved();
    logic [N-1:0] g, rv, g2; logic w, r, re, w2, r2; logic [DW-1:0] qd, rd; int gl, rl;
    logic seen;
    seen = 1'b0;
    wait_idle();
    i_req[0] = 1'b1; i_op[1:0] = 2'b00; i_data[DW-1:0] = 16'd77;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge CLK);
      if (o_gnt[0] === 1'b1) seen = 1'b1;
    end
    RST = 1'b1; i_req = '0;
    @(negedge CLK);
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL midop_gnt: got seen=%b, expected 1", seen); end
    n_cmp++; if (o_rsp_valid !== '0 || o_busy !== 1'b0 || o_gnt !== '0 || o_q_wrt !== 1'b0) begin n_fail++; $display("FAIL midop_reset: got v=%b busy=%b gnt=%b wrt=%b, expected 0000/0/0000/0", o_rsp_valid, o_busy, o_gnt, o_q_wrt); end
    RST = 1'b0;
    @(negedge CLK);
    n_cmp++; if (o_rsp_valid !== '0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL midop_after: got v=%b busy=%b, expected 0000/0", o_rsp_valid, o_busy); end
    n_cmp++; if (qm.size() != 3 || qm[0] !== 16'd77) begin n_fail++; $display("FAIL midop_issued: got size=%0d root=%0d, expected 3/77", qm.size(), qm[0]); end
    run_op(0, 2'b11, 16'd123, g, w, r, qd, rv, rd, re, gl, rl, w2, r2, g2);
    n_cmp++; if (g !== 4'b0001 || w !== 1'b0 || r !== 1'b0) begin n_fail++; $display("FAIL resv_strobe: got gnt=%b wrt=%b read=%b, expected 0001/0/0", g, w, r); end
    n_cmp++; if (rv !== 4'b0001 || re !== 1'b1 || rd !== '0) begin n_fail++; $display("FAIL resv_rsp: got v=%b err=%b data=%0d, expected 0001/1/0", rv, re, rd); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_full_reject();
    test_dequeue_order();
    test_replace();
    test_reset_midop_reserved();
    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
